// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART bus controller: TX FSM state encoding,
// parameter defaults and the peripheral address map of the UART registers.
package uart_ctrl_pkg;

   // Parameter defaults
   localparam int unsigned TxDepthDefault    = 8;
   localparam int unsigned AckTimeoutDefault = 4;

   // Peripheral address map (decoded upstream, listed here for software and decoder use)
   localparam logic [31:0] UartTxAddr    = 32'h1001_002C;
   localparam logic [31:0] UartRxAddr    = 32'h1001_0030;
   localparam logic [31:0] UartBusyAddr  = 32'h1001_0034;
   localparam logic [31:0] UartReadyAddr = 32'h1001_0038;

   // TX sequencer states
   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StWaitBusy,
      StWaitDone
   } tx_state_e;

   // Width of an occupancy counter able to hold the value depth itself
   function automatic int unsigned level_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word fall-through FIFO for the UART TX path. A push is
// accepted only when the FIFO is not full at that cycle, even if a pop happens
// in the same cycle. The head entry is visible on head whenever empty is low.
module uart_tx_fifo
   import uart_ctrl_pkg::*;
#(
   parameter int unsigned Depth = TxDepthDefault,
   parameter int unsigned Width = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  logic [Width-1:0]        push_data,
   input  logic                    pop,
   output logic [Width-1:0]        head,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(Depth):0]  level
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] FullCount = Depth[CntW-1:0];

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q;
   logic [PtrW-1:0]  rd_ptr_q;
   logic [CntW-1:0]  count_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == FullCount);
   assign empty   = (count_q == '0);
   assign level   = count_q;
   assign head    = mem_q[rd_ptr_q];

   // Full is judged before any same-cycle pop, so a full FIFO never accepts
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Pointer and occupancy bookkeeping; pointers wrap naturally modulo Depth
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + PtrW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage array; contents need no reset because occupancy gates every read
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/uart_bus_ctrl.sv
// UART bus controller: queues CPU writes to the TX address in a small FIFO and
// feeds them to the TX core one byte at a time, holds the last received byte
// with a ready flag, and reports FIFO state for the status registers.
// Optional sticky error flags (tx_overflow, rx_overrun, clr_err) are built
// only when UART_CTRL_ERR_FLAGS_EN is defined; otherwise they read as zero.
module uart_bus_ctrl
   import uart_ctrl_pkg::*;
#(
   parameter int unsigned TX_DEPTH    = TxDepthDefault,
   parameter int unsigned ACK_TIMEOUT = AckTimeoutDefault
) (
   input  logic                       clk,
   input  logic                       reset,
   // CPU side
   input  logic                       wr_tx_en,
   input  logic [7:0]                 wr_data,
   input  logic                       rd_rx_en,
   input  logic                       clr_err,
   // TX core
   input  logic                       tx_busy,
   output logic                       tx_start,
   output logic [7:0]                 tx_data,
   // RX core
   input  logic                       rx_valid,
   input  logic [7:0]                 rx_byte,
   // Status and RX holding register
   output logic [7:0]                 rx_data,
   output logic                       rx_ready,
   output logic                       tx_full,
   output logic                       tx_empty,
   output logic [$clog2(TX_DEPTH):0]  tx_level,
   output logic                       tx_idle,
   output logic                       tx_overflow,
   output logic                       rx_overrun
);

   // Timeout counter counts WAIT_BUSY cycles 0 .. ACK_TIMEOUT-1
   localparam int unsigned ToW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [ToW-1:0] ToLast = ToW'(ACK_TIMEOUT - 1);

   tx_state_e        state_q;
   tx_state_e        state_d;
   logic [ToW-1:0]   to_cnt_q;
   logic [7:0]       tx_data_q;
   logic [7:0]       fifo_head;
   logic             fifo_pop;
   logic             load_data;
   logic [7:0]       rx_data_q;
   logic             rx_ready_q;

   uart_tx_fifo #(
      .Depth (TX_DEPTH),
      .Width (8)
   ) u_tx_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (wr_tx_en),
      .push_data (wr_data),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (tx_full),
      .empty     (tx_empty),
      .level     (tx_level)
   );

   // ---------------------------------------------------------------------------
   // TX sequencer
   // ---------------------------------------------------------------------------

   // State register; reset drops the controller straight back to idle
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a missing busy acknowledge counts the byte as sent
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (!tx_empty) begin
               state_d = StStart;
            end
         end
         StStart: begin
            state_d = StWaitBusy;
         end
         StWaitBusy: begin
            if (tx_busy) begin
               state_d = StWaitDone;
            end else if (to_cnt_q == ToLast) begin
               state_d = StIdle;
            end
         end
         StWaitDone: begin
            if (!tx_busy) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Output decode from the state register only, so tx_start cannot glitch
   always_comb begin
      tx_start  = 1'b0;
      fifo_pop  = 1'b0;
      load_data = 1'b0;
      unique case (state_q)
         StIdle: begin
            load_data = ~tx_empty;
         end
         StStart: begin
            tx_start = 1'b1;
            fifo_pop = 1'b1;
         end
         default: begin
            load_data = 1'b0;
         end
      endcase
   end

   // Acknowledge timeout counter, cleared whenever not waiting for busy
   always_ff @(posedge clk) begin
      if (reset) begin
         to_cnt_q <= '0;
      end else if (state_q == StWaitBusy) begin
         to_cnt_q <= to_cnt_q + ToW'(1);
      end else begin
         to_cnt_q <= '0;
      end
   end

   // Byte presented to the TX core, captured on the IDLE -> START transition
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_data_q <= '0;
      end else if (load_data) begin
         tx_data_q <= fifo_head;
      end
   end

   assign tx_data = tx_data_q;
   assign tx_idle = tx_empty & (state_q == StIdle);

   // ---------------------------------------------------------------------------
   // RX holding register
   // ---------------------------------------------------------------------------

   // A new byte always wins over a read; a read only clears a pending byte
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_data_q  <= '0;
         rx_ready_q <= 1'b0;
      end else if (rx_valid) begin
         rx_data_q  <= rx_byte;
         rx_ready_q <= 1'b1;
      end else if (rd_rx_en) begin
         rx_ready_q <= 1'b0;
      end
   end

   assign rx_data  = rx_data_q;
   assign rx_ready = rx_ready_q;

   // ---------------------------------------------------------------------------
   // Sticky error flags
   // ---------------------------------------------------------------------------

`ifdef UART_CTRL_ERR_FLAGS_EN
   logic tx_overflow_q;
   logic rx_overrun_q;
   logic ovf_event;
   logic ovr_event;

   assign ovf_event = wr_tx_en & tx_full;
   // Reading in the same cycle as a new byte arrives is not an overrun
   assign ovr_event = rx_valid & rx_ready_q & ~rd_rx_en;

   // Sticky flags; a same-cycle error event outranks clr_err
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_overflow_q <= 1'b0;
         rx_overrun_q  <= 1'b0;
      end else begin
         if (ovf_event) begin
            tx_overflow_q <= 1'b1;
         end else if (clr_err) begin
            tx_overflow_q <= 1'b0;
         end
         if (ovr_event) begin
            rx_overrun_q <= 1'b1;
         end else if (clr_err) begin
            rx_overrun_q <= 1'b0;
         end
      end
   end

   assign tx_overflow = tx_overflow_q;
   assign rx_overrun  = rx_overrun_q;
`else
   logic unused_clr_err;

   assign unused_clr_err = clr_err;
   assign tx_overflow    = 1'b0;
   assign rx_overrun     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_bus_ctrl.sv
// Self-checking bench for uart_bus_ctrl: a transaction-level model (byte queue,
// start/ack timing rules, RX holding register) is compared against the DUT on
// every cycle, plus directed scenarios with hand-computed expectations.
// Honours UART_CTRL_ERR_FLAGS_EN for the expected sticky-flag values.
module tb_uart_bus_ctrl;

   localparam int unsigned Depth = 8;
   localparam int          AckTo = 4;
`ifdef UART_CTRL_ERR_FLAGS_EN
   localparam bit ErrEn = 1'b1;
`else
   localparam bit ErrEn = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       wr_tx_en = 1'b0;
   logic [7:0] wr_data = '0;
   logic       rd_rx_en = 1'b0;
   logic       clr_err = 1'b0;
   logic       tx_busy = 1'b0;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_byte = '0;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       tx_full;
   logic       tx_empty;
   logic [3:0] tx_level;
   logic       tx_idle;
   logic       tx_overflow;
   logic       rx_overrun;

   uart_bus_ctrl #(
      .TX_DEPTH    (Depth),
      .ACK_TIMEOUT (AckTo)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .wr_tx_en    (wr_tx_en),
      .wr_data     (wr_data),
      .rd_rx_en    (rd_rx_en),
      .clr_err     (clr_err),
      .tx_busy     (tx_busy),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .rx_valid    (rx_valid),
      .rx_byte     (rx_byte),
      .rx_data     (rx_data),
      .rx_ready    (rx_ready),
      .tx_full     (tx_full),
      .tx_empty    (tx_empty),
      .tx_level    (tx_level),
      .tx_idle     (tx_idle),
      .tx_overflow (tx_overflow),
      .rx_overrun  (rx_overrun)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_d);
      end
   endtask

   // Cycle counter and TX core model: busy rises core_delay cycles after a start
   // and stays high for core_len cycles, or never rises when core_never is set.
   int cyc_d = 0;
   int core_rise = 0;
   int core_fall = 0;
   int core_delay = 1;
   int core_len = 10;
   bit core_never = 1'b0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc_d++;
         tx_busy = (cyc_d >= core_rise) && (cyc_d < core_fall);
      end
   end

   // Behavioural model state
   logic [7:0] m_q[$];
   bit         m_on = 1'b0;
   bit         m_idle = 1'b1;
   int         m_start = -1;
   bit         m_wait = 1'b0;
   bit         m_frame = 1'b0;
   logic [7:0] m_data = '0;
   logic [7:0] m_rx_data = '0;
   bit         m_rx_ready = 1'b0;
   bit         m_ovf = 1'b0;
   bit         m_ovr = 1'b0;

   logic [7:0] sent_q[$];
   int         start_q[$];

   task automatic model_reset();
      m_q.delete();
      m_idle     = 1'b1;
      m_start    = -1;
      m_wait     = 1'b0;
      m_frame    = 1'b0;
      m_data     = '0;
      m_rx_data  = '0;
      m_rx_ready = 1'b0;
      m_ovf      = 1'b0;
      m_ovr      = 1'b0;
      m_on       = 1'b1;
   endtask

   // Advance the model by one cycle using this cycle's inputs
   task automatic model_step();
      int sz;
      bit was_full;
      bit nxt_idle;
      bit ovf_ev;
      bit ovr_ev;
      sz       = m_q.size();
      was_full = (sz == Depth);
      nxt_idle = m_idle;
      // Frame in progress ends when busy drops; controller is free next cycle
      if (m_frame && !tx_busy) begin
         m_frame  = 1'b0;
         nxt_idle = 1'b1;
      end
      // Acknowledge window: the AckTo cycles after a start
      if (m_wait && cyc_d > m_start) begin
         if (tx_busy) begin
            m_wait  = 1'b0;
            m_frame = 1'b1;
         end else if (cyc_d == m_start + AckTo) begin
            m_wait   = 1'b0;
            nxt_idle = 1'b1;
         end
      end
      if (cyc_d == m_start) begin
         void'(m_q.pop_front());
         m_wait = 1'b1;
      end
      if (m_idle && sz > 0) begin
         m_start  = cyc_d + 1;
         m_data   = m_q[0];
         nxt_idle = 1'b0;
      end
      ovf_ev = wr_tx_en && was_full;
      ovr_ev = rx_valid && m_rx_ready && !rd_rx_en;
      if (wr_tx_en && !was_full) begin
         m_q.push_back(wr_data);
      end
      if (ErrEn) begin
         if (ovf_ev) m_ovf = 1'b1;
         else if (clr_err) m_ovf = 1'b0;
         if (ovr_ev) m_ovr = 1'b1;
         else if (clr_err) m_ovr = 1'b0;
      end
      if (rx_valid) begin
         m_rx_data  = rx_byte;
         m_rx_ready = 1'b1;
      end else if (rd_rx_en) begin
         m_rx_ready = 1'b0;
      end
      m_idle = nxt_idle;
   endtask

   // Compare process: check every output each cycle, then advance the model
   always @(negedge clk) begin
      if (m_on) begin
         chk("tx_start", {31'd0, tx_start}, {31'd0, cyc_d == m_start});
         chk("tx_level", {28'd0, tx_level}, m_q.size());
         chk("tx_empty", {31'd0, tx_empty}, {31'd0, m_q.size() == 0});
         chk("tx_full", {31'd0, tx_full}, {31'd0, m_q.size() == Depth});
         chk("tx_idle", {31'd0, tx_idle}, {31'd0, m_idle && m_q.size() == 0});
         if (!m_idle) chk("tx_data", {24'd0, tx_data}, {24'd0, m_data});
         chk("rx_data", {24'd0, rx_data}, {24'd0, m_rx_data});
         chk("rx_ready", {31'd0, rx_ready}, {31'd0, m_rx_ready});
         chk("tx_overflow", {31'd0, tx_overflow}, {31'd0, m_ovf});
         chk("rx_overrun", {31'd0, rx_overrun}, {31'd0, m_ovr});
      end
      if (tx_start === 1'b1) begin
         sent_q.push_back(tx_data);
         start_q.push_back(cyc_d);
         if (!core_never) begin
            core_rise = cyc_d + core_delay;
            core_fall = cyc_d + core_delay + core_len;
         end
      end
      if (reset) model_reset();
      else if (m_on) model_step();
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int bound);
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (tx_idle === 1'b1) break;
      end
      chk("wait_idle", {31'd0, tx_idle}, 32'd1);
   endtask

   logic [7:0] exp_burst[9] = '{8'hEE, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};

   initial begin
      int n0;
      // Reset state
      repeat (3) step();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
      chk("rst_tx_data", {24'd0, tx_data}, 32'h00);
      chk("rst_tx_empty", {31'd0, tx_empty}, 32'd1);
      chk("rst_tx_full", {31'd0, tx_full}, 32'd0);
      chk("rst_tx_level", {28'd0, tx_level}, 32'd0);
      chk("rst_tx_idle", {31'd0, tx_idle}, 32'd1);
      chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
      chk("rst_rx_data", {24'd0, rx_data}, 32'h00);
      chk("rst_flags", {30'd0, tx_overflow, rx_overrun}, 32'd0);

      // Single byte: start two cycles after the write
      core_delay = 1;
      core_len   = 10;
      step(); wr_tx_en = 1'b1; wr_data = 8'h41;
      step(); wr_tx_en = 1'b0;
      @(negedge clk);
      chk("wr_k1_empty", {31'd0, tx_empty}, 32'd0);
      chk("wr_k1_start", {31'd0, tx_start}, 32'd0);
      step();
      @(negedge clk);
      chk("wr_k2_start", {31'd0, tx_start}, 32'd1);
      chk("wr_k2_data", {24'd0, tx_data}, 32'h41);
      chk("wr_k2_idle", {31'd0, tx_idle}, 32'd0);
      wait_idle(50);

      // Burst while the core is busy with a previous byte: ninth write dropped
      sent_q.delete();
      start_q.delete();
      core_len = 40;
      step(); wr_tx_en = 1'b1; wr_data = 8'hEE;
      step(); wr_tx_en = 1'b0;
      repeat (4) step();
      for (int i = 0; i < 9; i++) begin
         wr_tx_en = 1'b1;
         wr_data  = 8'(i);
         step();
      end
      wr_tx_en = 1'b0;
      core_len = 3;
      @(negedge clk);
      chk("burst_full", {31'd0, tx_full}, 32'd1);
      chk("burst_level", {28'd0, tx_level}, 32'd8);
      chk("burst_overflow", {31'd0, tx_overflow}, {31'd0, ErrEn});
      wait_idle(300);
      chk("burst_count", sent_q.size(), 32'd9);
      for (int i = 0; i < 9; i++) begin
         chk("burst_order", (i < sent_q.size()) ? {24'd0, sent_q[i]} : 32'hDEAD,
             {24'd0, exp_burst[i]});
      end

      // No busy acknowledge: timeout after AckTo cycles, next byte starts
      sent_q.delete();
      start_q.delete();
      core_never = 1'b1;
      step(); wr_tx_en = 1'b1; wr_data = 8'h61;
      step(); wr_data = 8'h62;
      step(); wr_tx_en = 1'b0;
      wait_idle(100);
      core_never = 1'b0;
      chk("to_starts", start_q.size(), 32'd2);
      chk("to_gap", (start_q.size() == 2) ? start_q[1] - start_q[0] : -1, 32'd6);
      chk("to_second", (sent_q.size() == 2) ? {24'd0, sent_q[1]} : 32'hDEAD, 32'h62);

      // RX overwrite without read, then clear
      step(); rx_valid = 1'b1; rx_byte = 8'h55;
      step(); rx_byte = 8'hAA;
      step(); rx_valid = 1'b0;
      @(negedge clk);
      chk("ovr_data", {24'd0, rx_data}, 32'hAA);
      chk("ovr_ready", {31'd0, rx_ready}, 32'd1);
      chk("ovr_flag", {31'd0, rx_overrun}, {31'd0, ErrEn});
      step(); clr_err = 1'b1;
      step(); clr_err = 1'b0;
      @(negedge clk);
      chk("clr_ovr", {31'd0, rx_overrun}, 32'd0);
      chk("clr_ovf", {31'd0, tx_overflow}, 32'd0);

      // Read and new byte in the same cycle: no overrun
      step(); rd_rx_en = 1'b1;
      step(); rd_rx_en = 1'b0; rx_valid = 1'b1; rx_byte = 8'h34;
      step(); rx_valid = 1'b0;
      step(); rx_valid = 1'b1; rx_byte = 8'h12; rd_rx_en = 1'b1;
      step(); rx_valid = 1'b0; rd_rx_en = 1'b0;
      @(negedge clk);
      chk("rdnew_data", {24'd0, rx_data}, 32'h12);
      chk("rdnew_ready", {31'd0, rx_ready}, 32'd1);
      chk("rdnew_ovr", {31'd0, rx_overrun}, 32'd0);
      step(); rd_rx_en = 1'b1;
      step(); rd_rx_en = 1'b0;
      @(negedge clk);
      chk("rd_clears", {31'd0, rx_ready}, 32'd0);

      // Reset during WAIT_DONE with three bytes queued
      core_delay = 1;
      core_len   = 30;
      step(); wr_tx_en = 1'b1; wr_data = 8'hA0;
      step(); wr_data = 8'hA1;
      step(); wr_data = 8'hA2;
      step(); wr_data = 8'hA3;
      step(); wr_tx_en = 1'b0;
      step();
      @(negedge clk);
      chk("prerst_level", {28'd0, tx_level}, 32'd3);
      step(); reset = 1'b1;
      step(); reset = 1'b0;
      @(negedge clk);
      chk("midrst_level", {28'd0, tx_level}, 32'd0);
      chk("midrst_start", {31'd0, tx_start}, 32'd0);
      chk("midrst_idle", {31'd0, tx_idle}, 32'd1);
      n0 = start_q.size();
      repeat (40) step();
      chk("midrst_nostart", start_q.size(), n0);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         step();
         reset      = ($urandom_range(499) == 0);
         wr_tx_en   = ($urandom_range(99) < 40);
         wr_data    = 8'($urandom);
         rx_valid   = ($urandom_range(99) < 15);
         rx_byte    = 8'($urandom);
         rd_rx_en   = ($urandom_range(99) < 20);
         clr_err    = ($urandom_range(99) < 5);
         core_never = ($urandom_range(5) == 0);
         core_delay = int'($urandom_range(6, 1));
         core_len   = int'($urandom_range(8, 1));
      end
      step();
      reset = 1'b0; wr_tx_en = 1'b0; rx_valid = 1'b0; rd_rx_en = 1'b0; clr_err = 1'b0;
      repeat (5) step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule
